// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies, FSM state type and the funct-to-op decode helper.
package mdu_unit_pkg;

    localparam logic [2:0] MDU_OP_MULT  = 3'd0;
    localparam logic [2:0] MDU_OP_MULTU = 3'd1;
    localparam logic [2:0] MDU_OP_DIV   = 3'd2;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd5;
    localparam logic [2:0] MDU_OP_NOP   = 3'd7;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    // mfhi/mflo map to NOP: Execute serves them straight from hi/lo.
    function automatic logic [2:0] mdu_op_from_funct(input logic [5:0] funct);
        logic [2:0] op;
        case (funct)
            6'h18:   op = MDU_OP_MULT;
            6'h19:   op = MDU_OP_MULTU;
            6'h1a:   op = MDU_OP_DIV;
            6'h1b:   op = MDU_OP_DIVU;
            6'h11:   op = MDU_OP_MTHI;
            6'h13:   op = MDU_OP_MTLO;
            default: op = MDU_OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Execute-side request and HI/LO result bundle of the multiply/divide unit.
// Handshake: a request is taken on a rising edge where valid & start & !busy;
// any other start is ignored, and busy is a pure register with no input path.
interface mdu_unit_if;
    logic        valid;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output valid, start, op, rs_val, rt_val, input busy, hi, lo);
    modport slave  (input valid, start, op, rs_val, rt_val, output busy, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// Fixed-latency multiply/divide unit holding HI/LO. Results are computed at
// accept into pending registers and committed when the down-counter expires.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    mdu_unit_if.slave  bus,
    output mdu_state_t state
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    logic              busy_q;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       hi_q, lo_q;
    logic [31:0]       pend_hi, pend_lo;
    logic              pend_we;

    logic              accept;
    logic [63:0]       prod_s, prod_u;
    logic              a_neg, b_neg, div_zero;
    logic [31:0]       a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    assign accept = bus.valid & bus.start & ~busy_q;
    assign prod_s = 64'($signed(bus.rs_val)) * 64'($signed(bus.rt_val));
    assign prod_u = 64'(bus.rs_val) * 64'(bus.rt_val);

    // Sign-magnitude division: never overflows (0x80000000 / -1 falls out
    // naturally) and a zero divisor is swapped for 1 since its result is dropped.
    always_comb begin
        a_neg    = (bus.op == MDU_OP_DIV) & bus.rs_val[31];
        b_neg    = (bus.op == MDU_OP_DIV) & bus.rt_val[31];
        a_mag    = a_neg ? (32'd0 - bus.rs_val) : bus.rs_val;
        b_mag    = b_neg ? (32'd0 - bus.rt_val) : bus.rt_val;
        div_zero = (bus.rt_val == 32'd0);
        b_safe   = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem      = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MDU_IDLE;
            busy_q  <= 1'b0;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (accept) begin
                        case (bus.op)
                            MDU_OP_MULT, MDU_OP_MULTU: begin
                                pend_hi <= (bus.op == MDU_OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                                pend_lo <= (bus.op == MDU_OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                                pend_we <= 1'b1;
                                cnt     <= MULT_LOAD;
                                busy_q  <= 1'b1;
                                state   <= MDU_BUSY;
                            end
                            MDU_OP_DIV, MDU_OP_DIVU: begin
                                pend_hi <= rem;
                                pend_lo <= quot;
                                pend_we <= ~div_zero;
                                cnt     <= DIV_LOAD;
                                busy_q  <= 1'b1;
                                state   <= MDU_BUSY;
                            end
                            MDU_OP_MTHI: hi_q <= bus.rs_val;
                            MDU_OP_MTLO: lo_q <= bus.rs_val;
                            default: ;
                        endcase
                    end
                end
                MDU_BUSY: begin
                    if (cnt == '0) begin
                        if (pend_we) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        busy_q <= 1'b0;
                        state  <= MDU_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // A start during busy is dropped; Decode is expected to stall it.
    start_while_busy: assert property (@(posedge clk) disable iff (reset)
        !(bus.valid && bus.start && busy_q))
        else $warning("mdu_unit: start while busy ignored");

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit inside the Execute stage of the 5-stage MIPS pipeline.
- Executes mult, multu, div, divu with fixed multi-cycle latency and holds the HI and LO registers.
- Handles mthi and mtlo; mfhi and mflo are served by Execute selecting `hi`/`lo`.
- The hazard unit consumes `busy`/`start` to stall MD-class instructions in Decode.

Parameters:
MULT_CYCLES, 5, cycles busy is held high for mult/multu (>=1)
DIV_CYCLES, 10, cycles busy is held high for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
valid  input  1  Execute instruction is real (low for bubbles/latency slots); gates start
start  input  1  launch request for one cycle, from Execute decode
op  input  3  operation: see MDU_OP constants
rs_val  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
rt_val  input  32  forwarded rt operand (divisor / multiplier)
busy  output  1  operation in flight
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset (async, any time incl. mid-operation): busy=0, hi=0, lo=0, counter=0, pending results discarded; no later commit.
- Accept condition: `valid & start & !busy`. Otherwise start is ignored; it must never occur while busy, and a simulation assertion flags it.
- Ops: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6-7 are no-ops.
- mult/multu, accepted at edge t0:
  - {hi,lo} = 64-bit signed/unsigned product, captured into pending registers at t0.
  - busy=1 during cycles t0+1 .. t0+MULT_CYCLES.
  - At edge t0+MULT_CYCLES, hi/lo take pending values and busy falls.
  - hi/lo keep their old values throughout the busy window.
- div/divu: same timing with DIV_CYCLES.
  - lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend (signed case).
- Divide by zero: busy runs the full DIV_CYCLES; hi/lo are left unchanged at commit.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no trap.
- mthi/mtlo accepted at edge t0: hi (resp. lo) = rs_val at t0; busy stays 0; single-cycle.
- Counter: down-counter loaded with latency-1 on accept, decremented while busy; commit when it reaches 0 while busy.
  - Width is clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1.
- Back-to-back: a new accept is legal in the cycle immediately after busy falls. hi/lo reflect the previous result at that point.
- Hazard contract, implemented outside this block:
  - The hazard unit stalls Decode while an MD-class instruction is in D and (busy | (start & valid)).
  - `busy` therefore has no combinational path from inputs; it is a pure register output.

Decomposition:
- Shared package:
  - MDU_OP_* 3-bit encodings.
  - Default latency constants MDU_MULT_CYCLES and MDU_DIV_CYCLES.
  - A function mapping instruction funct codes to MDU ops, for reuse by the Execute and hazard logic.
- No sub-module: product and quotient use built-in operators captured into pending registers, plus a counter. All of this sits in one module of roughly 150 lines.

Test Plan:
- mult with rs=0xFFFFFFFF, rt=2:
  - busy is high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - Same operands with multu give hi=0x00000001, lo=0xFFFFFFFE.
- div with rs=-7 (0xFFFFFFF9), rt=2: busy is high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with 7/2 gives lo=3, hi=1.
- Divide by zero: preload hi=0x11, lo=0x22 via mthi/mtlo, then div by 0. busy is high 10 cycles, and afterwards hi=0x11, lo=0x22.
- mthi with rs=0x1234: hi=0x1234 at the next edge, busy stays 0, lo unchanged.
- Ignored starts:
  - start with valid=0: no busy, no change.
  - start while busy: ignored and assertion fires; the original result commits at its scheduled cycle.
- Reset mid-operation: assert reset 3 cycles into a div. busy=0, hi=lo=0 immediately (async), and no commit occurs afterwards.
